morse_letter_ctrl: RTL and testbench
====================================

MORSE_LETTER_CTRL -- requirements
Module: morse_letter_ctrl

Interface
REQ-001 Parameter SHORT_MAX, default 2000, max press length in ticks classified as short.
REQ-002 Parameter LONG_MIN, default 4000, min press length in ticks classified as long.
REQ-003 Parameter LONG_MAX, default 7000, max press length in ticks classified as long.
REQ-004 Parameter GAP_TICKS, default 7000, release length in ticks that auto-closes a letter.
REQ-005 clk  in  1  single system clock, all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 tick_en  in  1  one-cycle timebase strobe; all durations count tick_en pulses.
REQ-008 key_state  in  1  debounced key level, 0 = pressed.
REQ-009 key_down / key_up  in  1 each  one-cycle debounced press/release strobes.
REQ-010 del_pulse / fin_pulse  in  1 each  one-cycle debounced delete-last / finish-letter strobes.
REQ-011 letter  out  10  packed letter, 2 bits per symbol, newest symbol in bits [1:0].
REQ-012 letter_valid  out  1  letter offered to converter; letter_ready  in  1  converter accepts.
REQ-013 sym_count  out  3  symbols currently buffered (0..5).
REQ-014 led_short / led_long / led_null  out  1 each  live classification of the press in progress.
REQ-015 err  out  1  one-cycle pulse on rejected press or overflow.

Function
REQ-016 Symbol codes: short = 2'b10, long = 2'b11, empty slot = 2'b00.
REQ-017 States IDLE, PRESSED, GAP, EMIT.
REQ-018 IDLE: key_down -> PRESSED, duration counter cleared to 0.
REQ-019 PRESSED: counter +1 per tick_en, saturating at 16'hFFFF.
REQ-020 PRESSED on key_up: 1..SHORT_MAX -> append short; LONG_MIN..LONG_MAX -> append long; 0, between SHORT_MAX and LONG_MIN, or >LONG_MAX -> no append, err pulse; then -> GAP with gap counter cleared.
REQ-021 Append = letter <= {letter[7:0], code}, sym_count+1, effective the cycle after key_up.
REQ-022 Append with sym_count = 5: buffer unchanged, err pulse.
REQ-023 GAP: gap counter +1 per tick_en; key_down -> PRESSED.
REQ-024 GAP: fin_pulse with sym_count > 0, or gap counter reaching GAP_TICKS with sym_count > 0 -> EMIT.
REQ-025 GAP with sym_count = 0 and fin_pulse or gap timeout -> IDLE, no emit.
REQ-026 del_pulse in IDLE or GAP: letter <= {2'b00, letter[9:2]}, sym_count-1; no effect when sym_count = 0; GAP -> IDLE if count reaches 0.
REQ-027 Same-cycle priority in GAP: fin_pulse > del_pulse > key_down; lower-priority events are dropped.
REQ-028 EMIT: letter_valid = 1, letter and sym_count held stable until letter_ready = 1.
REQ-029 EMIT handshake cycle: next cycle letter = 0, sym_count = 0, letter_valid = 0, state IDLE.
REQ-030 EMIT ignores key_down, del_pulse and fin_pulse.
REQ-031 del_pulse and fin_pulse ignored in PRESSED.
REQ-032 LEDs, PRESSED only: led_short = count > 0; led_long = count >= LONG_MIN; led_null = count > LONG_MAX; all 0 in other states.
REQ-033 key_up outside PRESSED is ignored; key_state only qualifies key_down (key_down with key_state = 1 ignored).

Reset
REQ-034 rst_n low asynchronously forces state IDLE, letter 0, sym_count 0, counters 0, letter_valid 0, err 0, all LEDs 0.
REQ-035 Reset asserted mid-press or mid-EMIT discards the buffered letter; no letter_valid is produced.
REQ-036 Reset deassertion is synchronised to clk before it affects state.

Structure
REQ-037 Package morse_pkg holds symbol codes, MAX_SYMBOLS = 5, letter width 10 and the state encoding.
REQ-038 One sub-module, morse_tick_counter: 16-bit saturating counter with clear and tick_en enable, instantiated for press and gap timing.

Verification (bench parameters SHORT_MAX=4, LONG_MIN=8, LONG_MAX=14, GAP_TICKS=20)
REQ-039 Presses of 3, 10, 2 ticks, then fin_pulse -> letter = 10'b00_0010_1110, sym_count = 3, letter_valid held until letter_ready.
REQ-040 Press of 6 ticks, then press of 16 ticks -> two err pulses, sym_count stays 0; led_null = 1 from tick 15 of the 16-tick press.
REQ-041 Six short presses -> sym_count = 5, letter = 10'b10_1010_1010, err pulse on the sixth press.
REQ-042 Long, short, del_pulse, 20 idle ticks -> letter_valid with letter = 10'b00_0000_0011, sym_count = 1.
REQ-043 fin_pulse and del_pulse in the same GAP cycle with 2 symbols -> EMIT with 2 symbols; with letter_ready = 0 for 5 cycles -> letter stable throughout.
REQ-044 rst_n low during EMIT -> letter_valid = 0 immediately, letter = 0, state IDLE after release.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse letter controller: symbol codes, letter
// geometry, timer width and FSM state encoding.
package morse_pkg;

    localparam int LETTER_W = 10;
    localparam int CNT_W    = 16;

    localparam logic [2:0] MAX_SYMBOLS = 3'd5;

    localparam logic [1:0] SYM_EMPTY = 2'b00;
    localparam logic [1:0] SYM_SHORT = 2'b10;
    localparam logic [1:0] SYM_LONG  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_GAP     = 2'd2,
        ST_EMIT    = 2'd3
    } state_t;

endpackage

// File: rtl/morse_tick_counter.sv
// 16-bit saturating duration counter advanced by the tick strobe; clear wins
// over increment so a new interval always starts from zero.
module morse_tick_counter
    import morse_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/morse_letter_ctrl.sv
// Collects timed key presses into a packed Morse letter of up to five symbols
// and offers it to a downstream converter through a valid/ready handshake.
module morse_letter_ctrl
    import morse_pkg::*;
#(
    parameter int SHORT_MAX = 2000,
    parameter int LONG_MIN  = 4000,
    parameter int LONG_MAX  = 7000,
    parameter int GAP_TICKS = 7000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_en,
    input  logic                key_state,
    input  logic                key_down,
    input  logic                key_up,
    input  logic                del_pulse,
    input  logic                fin_pulse,
    output logic [LETTER_W-1:0] letter,
    output logic                letter_valid,
    input  logic                letter_ready,
    output logic [2:0]          sym_count,
    output logic                led_short,
    output logic                led_long,
    output logic                led_null,
    output logic                err
);

    localparam logic [CNT_W-1:0] SHORT_MAX_C = CNT_W'(SHORT_MAX);
    localparam logic [CNT_W-1:0] LONG_MIN_C  = CNT_W'(LONG_MIN);
    localparam logic [CNT_W-1:0] LONG_MAX_C  = CNT_W'(LONG_MAX);
    localparam logic [CNT_W-1:0] GAP_TICKS_C = CNT_W'(GAP_TICKS);

    // Reset asserts immediately but releases only after two clean clock edges.
    logic [1:0]          r_rst_sync;
    logic                w_rst_n;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LETTER_W-1:0] r_letter;
    logic [LETTER_W-1:0] w_letter_nxt;
    logic [2:0]          r_sym_count;
    logic [2:0]          w_sym_count_nxt;
    logic                r_err;
    logic                w_err_nxt;

    logic                w_press_clr;
    logic                w_gap_clr;
    logic [CNT_W-1:0]    w_press_cnt;
    logic [CNT_W-1:0]    w_gap_cnt;
    logic                w_key_press;
    logic                w_gap_timeout;
    logic [1:0]          w_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    morse_tick_counter u_press_cnt (
        .clk     (clk),
        .rst_n   (w_rst_n),
        .i_clr   (w_press_clr),
        .i_en    (tick_en && (r_state == ST_PRESSED)),
        .o_count (w_press_cnt)
    );

    morse_tick_counter u_gap_cnt (
        .clk     (clk),
        .rst_n   (w_rst_n),
        .i_clr   (w_gap_clr),
        .i_en    (tick_en && (r_state == ST_GAP)),
        .o_count (w_gap_cnt)
    );

    // SYM_EMPTY marks a press length that falls in no accepted window.
    function automatic logic [1:0] classify(input logic [CNT_W-1:0] dur);
        if ((dur != '0) && (dur <= SHORT_MAX_C)) begin
            return SYM_SHORT;
        end else if ((dur >= LONG_MIN_C) && (dur <= LONG_MAX_C)) begin
            return SYM_LONG;
        end
        return SYM_EMPTY;
    endfunction

    assign w_key_press   = key_down && !key_state;
    assign w_gap_timeout = (w_gap_cnt >= GAP_TICKS_C);
    assign w_code        = classify(w_press_cnt);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= ST_IDLE;
            r_letter    <= '0;
            r_sym_count <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_letter    <= w_letter_nxt;
            r_sym_count <= w_sym_count_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_letter_nxt    = r_letter;
        w_sym_count_nxt = r_sym_count;
        w_err_nxt       = 1'b0;
        w_press_clr     = 1'b0;
        w_gap_clr       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (del_pulse && (r_sym_count != '0)) begin
                    w_letter_nxt    = {2'b00, r_letter[LETTER_W-1:2]};
                    w_sym_count_nxt = r_sym_count - 1'b1;
                end else if (w_key_press) begin
                    w_state_nxt = ST_PRESSED;
                    w_press_clr = 1'b1;
                end
            end

            ST_PRESSED: begin
                if (key_up) begin
                    w_state_nxt = ST_GAP;
                    w_gap_clr   = 1'b1;
                    if ((w_code == SYM_EMPTY) || (r_sym_count == MAX_SYMBOLS)) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_letter_nxt    = {r_letter[LETTER_W-3:0], w_code};
                        w_sym_count_nxt = r_sym_count + 1'b1;
                    end
                end
            end

            // Finish (or timeout) beats delete, which beats a new press.
            ST_GAP: begin
                if (fin_pulse || w_gap_timeout) begin
                    w_state_nxt = (r_sym_count != '0) ? ST_EMIT : ST_IDLE;
                end else if (del_pulse) begin
                    if (r_sym_count != '0) begin
                        w_letter_nxt    = {2'b00, r_letter[LETTER_W-1:2]};
                        w_sym_count_nxt = r_sym_count - 1'b1;
                        if (r_sym_count == 3'd1) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end else if (w_key_press) begin
                    w_state_nxt = ST_PRESSED;
                    w_press_clr = 1'b1;
                end
            end

            ST_EMIT: begin
                if (letter_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_letter_nxt    = '0;
                    w_sym_count_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign letter       = r_letter;
    assign sym_count    = r_sym_count;
    assign letter_valid = (r_state == ST_EMIT);
    assign err          = r_err;

    assign led_short = (r_state == ST_PRESSED) && (w_press_cnt != '0);
    assign led_long  = (r_state == ST_PRESSED) && (w_press_cnt >= LONG_MIN_C);
    assign led_null  = (r_state == ST_PRESSED) && (w_press_cnt > LONG_MAX_C);

endmodule

// File: tb/tb_morse_letter_ctrl.sv
// Directed bench for morse_letter_ctrl with short timing parameters
// (SHORT_MAX=4, LONG_MIN=8, LONG_MAX=14, GAP_TICKS=20).
module tb_morse_letter_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_en = 1'b0;
    logic       key_state = 1'b1;
    logic       key_down = 1'b0;
    logic       key_up = 1'b0;
    logic       del_pulse = 1'b0;
    logic       fin_pulse = 1'b0;
    logic       letter_ready = 1'b0;
    logic [9:0] letter;
    logic       letter_valid;
    logic [2:0] sym_count;
    logic       led_short;
    logic       led_long;
    logic       led_null;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    morse_letter_ctrl #(
        .SHORT_MAX (4),
        .LONG_MIN  (8),
        .LONG_MAX  (14),
        .GAP_TICKS (20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_en      (tick_en),
        .key_state    (key_state),
        .key_down     (key_down),
        .key_up       (key_up),
        .del_pulse    (del_pulse),
        .fin_pulse    (fin_pulse),
        .letter       (letter),
        .letter_valid (letter_valid),
        .letter_ready (letter_ready),
        .sym_count    (sym_count),
        .led_short    (led_short),
        .led_long     (led_long),
        .led_null     (led_null),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Key down, n tick strobes while held, key up; returns one cycle after key up.
    task automatic press(input int n);
        key_down  = 1'b1;
        key_state = 1'b0;
        cyc();
        key_down = 1'b0;
        tick_en  = 1'b1;
        repeat (n) cyc();
        tick_en   = 1'b0;
        key_up    = 1'b1;
        key_state = 1'b1;
        cyc();
        key_up = 1'b0;
    endtask

    task automatic pulse_fin();
        fin_pulse = 1'b1;
        cyc();
        fin_pulse = 1'b0;
    endtask

    task automatic accept();
        letter_ready = 1'b1;
        cyc();
        letter_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_letter", 16'(letter), 16'h000);
        chk("rst_count", 16'(sym_count), 16'd0);
        chk("rst_valid", 16'(letter_valid), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        chk("rst_leds", 16'({led_short, led_long, led_null}), 16'd0);
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();

        // key_down with key_state released is not a press
        key_down = 1'b1;
        cyc();
        key_down = 1'b0;
        tick_en  = 1'b1;
        cyc();
        tick_en = 1'b0;
        chk("keystate_qual_led", 16'(led_short), 16'd0);

        // Short 3, long 10, short 2, finish
        press(3);
        chk("a_count1", 16'(sym_count), 16'd1);
        chk("a_letter1", 16'(letter), 16'b10);
        chk("a_err1", 16'(err), 16'd0);
        press(10);
        press(2);
        chk("a_count3", 16'(sym_count), 16'd3);
        pulse_fin();
        for (int i = 0; i < 3; i++) begin
            chk("a_valid_hold", 16'(letter_valid), 16'd1);
            chk("a_letter_hold", 16'(letter), 16'b00_0010_1110);
            chk("a_count_hold", 16'(sym_count), 16'd3);
            cyc();
        end
        accept();
        chk("a_valid_done", 16'(letter_valid), 16'd0);
        chk("a_letter_clr", 16'(letter), 16'h000);
        chk("a_count_clr", 16'(sym_count), 16'd0);

        // Rejected presses: 6 ticks (between windows) and 16 ticks (too long)
        press(6);
        chk("b_err6", 16'(err), 16'd1);
        chk("b_count6", 16'(sym_count), 16'd0);
        cyc();
        chk("b_err_pulse_end", 16'(err), 16'd0);
        key_down  = 1'b1;
        key_state = 1'b0;
        cyc();
        key_down = 1'b0;
        tick_en  = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            if (i == 1)  chk("b_led_short_t1", 16'(led_short), 16'd1);
            if (i == 7)  chk("b_led_long_t7", 16'(led_long), 16'd0);
            if (i == 8)  chk("b_led_long_t8", 16'(led_long), 16'd1);
            if (i == 14) chk("b_led_null_t14", 16'(led_null), 16'd0);
            if (i == 15) chk("b_led_null_t15", 16'(led_null), 16'd1);
        end
        tick_en   = 1'b0;
        key_up    = 1'b1;
        key_state = 1'b1;
        cyc();
        key_up = 1'b0;
        chk("b_err16", 16'(err), 16'd1);
        chk("b_count16", 16'(sym_count), 16'd0);
        chk("b_leds_off", 16'({led_short, led_long, led_null}), 16'd0);
        press(0);
        chk("b_err0", 16'(err), 16'd1);
        pulse_fin();
        chk("b_no_emit", 16'(letter_valid), 16'd0);

        // Six short presses overflow the buffer
        for (int i = 0; i < 5; i++) press(1);
        chk("c_count5", 16'(sym_count), 16'd5);
        chk("c_letter5", 16'(letter), 16'b10_1010_1010);
        chk("c_err5", 16'(err), 16'd0);
        press(1);
        chk("c_err6", 16'(err), 16'd1);
        chk("c_count6", 16'(sym_count), 16'd5);
        chk("c_letter6", 16'(letter), 16'b10_1010_1010);
        pulse_fin();
        chk("c_valid", 16'(letter_valid), 16'd1);
        accept();

        // Long (14), short (4), delete, gap timeout
        press(14);
        press(4);
        chk("d_letter2", 16'(letter), 16'b00_0000_1110);
        del_pulse = 1'b1;
        cyc();
        del_pulse = 1'b0;
        chk("d_count_del", 16'(sym_count), 16'd1);
        chk("d_letter_del", 16'(letter), 16'b00_0000_0011);
        tick_en = 1'b1;
        repeat (20) cyc();
        tick_en = 1'b0;
        chk("d_valid_pre", 16'(letter_valid), 16'd0);
        cyc();
        chk("d_valid_timeout", 16'(letter_valid), 16'd1);
        chk("d_letter_emit", 16'(letter), 16'b00_0000_0011);
        chk("d_count_emit", 16'(sym_count), 16'd1);
        accept();

        // fin and del in the same GAP cycle; EMIT holds through ignored events
        press(1);
        press(8);
        fin_pulse = 1'b1;
        del_pulse = 1'b1;
        cyc();
        fin_pulse = 1'b0;
        del_pulse = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("e_valid", 16'(letter_valid), 16'd1);
            chk("e_letter", 16'(letter), 16'b00_0000_1011);
            chk("e_count", 16'(sym_count), 16'd2);
            del_pulse = (i == 1);
            fin_pulse = (i == 2);
            key_down  = (i == 3);
            key_state = (i == 3) ? 1'b0 : 1'b1;
            cyc();
        end
        del_pulse = 1'b0;
        fin_pulse = 1'b0;
        key_down  = 1'b0;
        key_state = 1'b1;
        chk("e_letter_after", 16'(letter), 16'b00_0000_1011);
        accept();
        chk("e_idle", 16'(letter_valid), 16'd0);

        // Reset during EMIT
        press(2);
        pulse_fin();
        chk("f_valid_pre", 16'(letter_valid), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("f_valid_async", 16'(letter_valid), 16'd0);
        chk("f_letter_async", 16'(letter), 16'h000);
        chk("f_count_async", 16'(sym_count), 16'd0);
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        chk("f_valid_post", 16'(letter_valid), 16'd0);
        press(2);
        chk("f_count_post", 16'(sym_count), 16'd1);
        chk("f_letter_post", 16'(letter), 16'b10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
